// File: rtl/glay_control_pkg.sv
// Shared kernel-control types for the compute-unit scheduler.
// State encoding, watchdog width and index-width helper.
package glay_control_pkg;

    localparam int CU_COUNT_GLOBAL         = 4;
    localparam int CU_SCHED_WATCHDOG_WIDTH = 32;

    typedef enum logic [2:0] {
        CU_SCHED_RESET,
        CU_SCHED_SETUP,
        CU_SCHED_ARMED,
        CU_SCHED_DISPATCH,
        CU_SCHED_WAIT,
        CU_SCHED_COMPLETE
    } cu_scheduler_state;

    function automatic int cu_sched_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/glay_kernel_cu_scheduler_if.sv
// Kernel-control <-> cluster-array bundle of the CU scheduler.
// master = kernel control / cluster side, slave = scheduler.
interface glay_kernel_cu_scheduler_if
    import glay_control_pkg::*;
#(
    parameter int NUM_GRAPH_CLUSTERS = CU_COUNT_GLOBAL
);

    logic                          descriptor_valid_in;
    logic [NUM_GRAPH_CLUSTERS-1:0] cu_setup_ack_in;
    logic [NUM_GRAPH_CLUSTERS-1:0] cu_done_in;
    logic [NUM_GRAPH_CLUSTERS-1:0] cu_start_out;
    logic [NUM_GRAPH_CLUSTERS-1:0] glay_cu_setup_out;
    logic [NUM_GRAPH_CLUSTERS-1:0] glay_cu_done_out;
    logic                          sched_error_out;

    modport master (
        output descriptor_valid_in,
        output cu_setup_ack_in,
        output cu_done_in,
        input  cu_start_out,
        input  glay_cu_setup_out,
        input  glay_cu_done_out,
        input  sched_error_out
    );

    modport slave (
        input  descriptor_valid_in,
        input  cu_setup_ack_in,
        input  cu_done_in,
        output cu_start_out,
        output glay_cu_setup_out,
        output glay_cu_done_out,
        output sched_error_out
    );

endinterface

// File: rtl/glay_kernel_cu_scheduler_watchdog.sv
// WAIT-state watchdog: counter, limit compare, sticky error.
// Only instantiated with GLAY_CU_SCHEDULER_WATCHDOG_EN defined.
module glay_kernel_cu_scheduler_watchdog
    import glay_control_pkg::*;
#(
    parameter logic [CU_SCHED_WATCHDOG_WIDTH-1:0] WATCHDOG_LIMIT = 32'd1_000_000
) (
    input  logic ap_clk,
    input  logic areset,
    input  logic wait_entry,
    input  logic in_wait,
    output logic timeout,
    output logic error
);

    localparam int W = CU_SCHED_WATCHDOG_WIDTH;

    logic [W-1:0] cnt_q;

    // fires on the WATCHDOG_LIMIT-th WAIT cycle
    assign timeout = in_wait && ((cnt_q + W'(1)) == WATCHDOG_LIMIT);

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            cnt_q <= '0;
            error <= 1'b0;
        end else begin
            if (wait_entry)
                cnt_q <= '0;
            else if (in_wait)
                cnt_q <= cnt_q + W'(1);
            if (timeout)
                error <= 1'b1;
        end
    end

endmodule

// File: rtl/glay_kernel_cu_scheduler.sv
// Gates CU setup, staggers per-cluster starts, collects sticky dones.
// Optional WAIT watchdog: define GLAY_CU_SCHEDULER_WATCHDOG_EN.
module glay_kernel_cu_scheduler
    import glay_control_pkg::*;
#(
    parameter int          NUM_GRAPH_CLUSTERS = CU_COUNT_GLOBAL,
    parameter logic [31:0] WATCHDOG_LIMIT     = 32'd1_000_000
) (
    input logic                        ap_clk,
    input logic                        areset,
    glay_kernel_cu_scheduler_if.slave  bus
);

    localparam int N  = NUM_GRAPH_CLUSTERS;
    localparam int IW = cu_sched_idx_width(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    cu_scheduler_state state_q, state_d;

    logic          valid_q;
    logic [N-1:0]  ack_q, done_in_q;
    logic [IW-1:0] idx_q, idx_d;
    logic [N-1:0]  started_q, started_d;
    logic [N-1:0]  start_q, start_d;
    logic [N-1:0]  setup_q, setup_d;
    logic [N-1:0]  done_q, done_d;
    logic          timeout, error;

    always_ff @(posedge ap_clk) begin
        if (areset) begin
            state_q   <= CU_SCHED_RESET;
            valid_q   <= 1'b0;
            ack_q     <= '0;
            done_in_q <= '0;
            idx_q     <= '0;
            started_q <= '0;
            start_q   <= '0;
            setup_q   <= '1;
            done_q    <= '0;
        end else begin
            state_q   <= state_d;
            valid_q   <= bus.descriptor_valid_in;
            ack_q     <= bus.cu_setup_ack_in;
            done_in_q <= bus.cu_done_in;
            idx_q     <= idx_d;
            started_q <= started_d;
            start_q   <= start_d;
            setup_q   <= setup_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        started_d = started_q;
        start_d   = '0;
        setup_d   = '0;
        done_d    = done_q;
        unique case (state_q)
            CU_SCHED_RESET: begin
                setup_d = ~ack_q;
                state_d = CU_SCHED_SETUP;
            end
            CU_SCHED_SETUP: begin
                setup_d = ~ack_q;
                if (&ack_q)
                    state_d = CU_SCHED_ARMED;
            end
            CU_SCHED_ARMED: begin
                idx_d = '0;
                if (valid_q)
                    state_d = CU_SCHED_DISPATCH;
            end
            CU_SCHED_DISPATCH: begin
                start_d[idx_q]   = 1'b1;
                started_d[idx_q] = 1'b1;
                // started_q is the pre-pulse view: dones for clusters not yet started drop
                done_d = done_q | (done_in_q & started_q);
                idx_d  = idx_q + 1'b1;
                if (idx_q == LAST)
                    state_d = CU_SCHED_WAIT;
            end
            CU_SCHED_WAIT: begin
                done_d = done_q | (done_in_q & started_q);
                if (&done_q)
                    state_d = CU_SCHED_COMPLETE;
                if (timeout)
                    done_d = '1;
            end
            CU_SCHED_COMPLETE: begin
                if (!valid_q) begin
                    done_d    = '0;
                    started_d = '0;
                    state_d   = CU_SCHED_ARMED;
                end
            end
            default: state_d = CU_SCHED_RESET;
        endcase
    end

`ifdef GLAY_CU_SCHEDULER_WATCHDOG_EN
    logic in_wait, wait_entry;

    assign in_wait    = (state_q == CU_SCHED_WAIT);
    assign wait_entry = !in_wait && (state_d == CU_SCHED_WAIT);

    glay_kernel_cu_scheduler_watchdog #(
        .WATCHDOG_LIMIT (WATCHDOG_LIMIT)
    ) u_watchdog (
        .ap_clk     (ap_clk),
        .areset     (areset),
        .wait_entry (wait_entry),
        .in_wait    (in_wait),
        .timeout    (timeout),
        .error      (error)
    );
`else
    assign timeout = 1'b0;
    assign error   = 1'b0;
`endif

    assign bus.cu_start_out      = start_q;
    assign bus.glay_cu_setup_out = setup_q;
    assign bus.glay_cu_done_out  = done_q;
    assign bus.sched_error_out   = error;

endmodule
